md_seq_ctrl: RTL and testbench

Sequencer for the multiply/divide resources and owner of the HI/LO registers in the Minisys-1A EX stage. It accepts one mult/multu/div/divu/mthi/mtlo operation at a time from EX. It drives the external pipelined multiplier IPs (fixed latency) and the AXI-stream divider IPs (variable latency), then writes HI/LO. It stalls the pipeline on structural and RAW hazards against HI/LO and serves mfhi/mflo reads.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_md_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the HI/LO multiply/divide sequencer.
// Contents: md_op opcode constants, sequencer state enum, and the
// {quotient, remainder} field positions of the divider result bus.
package md_pkg;
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic [2:0] {
      IDLE,
      MUL_WAIT,
      DIV_ISSUE,
      DIV_WAIT,
      DIV_DRAIN
   } md_state_t;

   localparam int QUOT_MSB = 63;
   localparam int QUOT_LSB = 32;
   localparam int REM_MSB  = 31;
   localparam int REM_LSB  = 0;
endpackage

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: multiply/divide sequencer and HI/LO register owner for EX.
// Ports:
//   clock, reset                    clock and synchronous active-high reset
//   md_valid, md_op, rs_val, rt_val HI/LO-class op offered by EX
//   rd_hi, rd_lo, hi_lo_data        mfhi/mflo read port
//   flush                           kill of any outstanding op
//   mul_a, mul_b, mul_signed, mul_p fixed-latency multiplier interface
//   div_*                           AXI-stream divider interface
//   stall, busy                     pipeline freeze / sequencer active
//   divide_zero, div_timeout        one-cycle status pulses
module md_seq_ctrl
   import md_pkg::*;
#(
   parameter int MUL_LAT     = 5,
   parameter int DIV_MAX_LAT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        md_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        rd_hi,
   input  logic        rd_lo,
   input  logic        flush,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_signed,
   input  logic [63:0] mul_p,
   output logic        div_tvalid,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   output logic        div_signed,
   input  logic        div_dout_tvalid,
   input  logic [63:0] div_dout,
   input  logic        div_zero,
   output logic [31:0] hi_lo_data,
   output logic        stall,
   output logic        busy,
   output logic        divide_zero,
   output logic        div_timeout
);
   localparam int CW = $clog2((MUL_LAT > DIV_MAX_LAT ? MUL_LAT : DIV_MAX_LAT) + 1);
   localparam logic [CW-1:0] MUL_END = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_END = CW'(DIV_MAX_LAT - 1);

   md_state_t     state;
   logic [CW-1:0] cnt;
   logic [31:0]   hi, lo;
   logic          op_ok, acc;

   assign op_ok      = (md_op >= MD_MULT) && (md_op <= MD_MTLO);
   assign acc        = (state == IDLE) && md_valid && op_ok && !flush;
   assign busy       = state != IDLE;
   assign stall      = busy && ((md_valid && op_ok) || rd_hi || rd_lo);
   assign hi_lo_data = rd_hi ? hi : lo;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         hi           <= '0;
         lo           <= '0;
         mul_a        <= '0;
         mul_b        <= '0;
         mul_signed   <= 1'b0;
         div_tvalid   <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         div_signed   <= 1'b0;
         divide_zero  <= 1'b0;
         div_timeout  <= 1'b0;
      end else begin
         div_tvalid  <= 1'b0;
         divide_zero <= 1'b0;
         div_timeout <= 1'b0;
         unique case (state)
            IDLE: if (acc) begin
               if (md_op == MD_MULT || md_op == MD_MULTU) begin
                  mul_a      <= rs_val;
                  mul_b      <= rt_val;
                  mul_signed <= md_op == MD_MULT;
                  cnt        <= '0;
                  state      <= MUL_WAIT;
               end else if (md_op == MD_DIV || md_op == MD_DIVU) begin
                  div_dividend <= rs_val;
                  div_divisor  <= rt_val;
                  div_signed   <= md_op == MD_DIV;
                  div_tvalid   <= 1'b1;
                  state        <= DIV_ISSUE;
               end else if (md_op == MD_MTHI) begin
                  hi <= rs_val;
               end else begin
                  lo <= rs_val;
               end
            end
            MUL_WAIT: begin
               if (flush) begin
                  state <= IDLE;
               end else if (cnt == MUL_END) begin
                  {hi, lo} <= mul_p;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DIV_ISSUE: begin
               cnt   <= '0;
               state <= flush ? IDLE : DIV_WAIT;
            end
            DIV_WAIT: begin
               if (div_dout_tvalid) begin
                  // A result coinciding with flush belongs to the killed op.
                  if (!flush && div_zero) begin
                     divide_zero <= 1'b1;
                  end else if (!flush) begin
                     lo <= div_dout[QUOT_MSB:QUOT_LSB];
                     hi <= div_dout[REM_MSB:REM_LSB];
                  end
                  state <= IDLE;
               end else if (flush) begin
                  state <= DIV_DRAIN;
               end else if (cnt == DIV_END) begin
                  div_timeout <= 1'b1;
                  state       <= DIV_DRAIN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DIV_DRAIN: if (div_dout_tvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb_md_seq_ctrl: self-checking bench for md_seq_ctrl with a 5-cycle
// multiplier model and a hand-driven divider result stream.
module tb_md_seq_ctrl;
   import md_pkg::*;

   logic        clock, reset, md_valid, rd_hi, rd_lo, flush;
   logic [2:0]  md_op;
   logic [31:0] rs_val, rt_val, mul_a, mul_b, div_dividend, div_divisor, hi_lo_data;
   logic        mul_signed, div_tvalid, div_signed, div_dout_tvalid, div_zero;
   logic        stall, busy, divide_zero, div_timeout;
   logic [63:0] mul_p, div_dout;
   logic [63:0] mpipe [4];

   int n_vec = 0;
   int n_bad = 0;

   md_seq_ctrl #(.MUL_LAT(5), .DIV_MAX_LAT(40)) dut (
      .clock(clock), .reset(reset), .md_valid(md_valid), .md_op(md_op),
      .rs_val(rs_val), .rt_val(rt_val), .rd_hi(rd_hi), .rd_lo(rd_lo),
      .flush(flush), .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
      .mul_p(mul_p), .div_tvalid(div_tvalid), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_signed(div_signed),
      .div_dout_tvalid(div_dout_tvalid), .div_dout(div_dout),
      .div_zero(div_zero), .hi_lo_data(hi_lo_data), .stall(stall),
      .busy(busy), .divide_zero(divide_zero), .div_timeout(div_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic signed [63:0] sa, sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return s ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
   endfunction

   // Four register stages after the DUT's operand registers: product is
   // ready when the DUT samples it on its fifth wait edge.
   always @(posedge clock) begin
      mpipe[0] <= prod(mul_a, mul_b, mul_signed);
      for (int i = 1; i < 4; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_p = mpipe[3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic h, input logic l, input logic f);
      md_valid = v; md_op = op; rs_val = a; rt_val = b; rd_hi = h; rd_lo = l; flush = f;
   endtask

   task automatic rd(input logic h, input logic l);
      rd_hi = h; rd_lo = l; #1;
   endtask

   task automatic mul_run(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      int c;
      drv(1, op, a, b, 0, 0, 0);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 0, 0, 0);
      #1;
      chk({nm, " mul_a"}, mul_a, a);
      chk({nm, " mul_b"}, mul_b, b);
      chk({nm, " mul_signed"}, 32'(mul_signed), (op == MD_MULT) ? 1 : 0);
      c = 0;
      while (busy && c < 20) begin
         c++;
         @(negedge clock);
         #1;
      end
      chk({nm, " busy cycles"}, c, 5);
      rd(1, 0); chk({nm, " HI"}, hi_lo_data, ehi);
      rd(0, 1); chk({nm, " LO"}, hi_lo_data, elo);
      rd(0, 0);
   endtask

   typedef struct {
      logic        v;
      logic [2:0]  op;
      logic [31:0] rs, rt;
      logic        h, l, f;
      logic [31:0] ed;
      logic        es, eb;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c;
      logic ok;
      vecs[0]  = '{1'b0, MD_NONE, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[1]  = '{1'b1, MD_MTHI, 32'h12345678, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[2]  = '{1'b0, MD_NONE, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, MD_MTLO, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
      vecs[4]  = '{1'b0, MD_NONE, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[5]  = '{1'b1, 3'd7,    32'h0000DEAD, 32'h1, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, MD_MTLO, 32'h22222222, 32'h0, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, MD_MTHI, 32'h11111111, 32'h0, 1'b0, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, MD_NONE, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, MD_NONE, 32'h00000099, 32'h0, 1'b0, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0};
      vecs[10] = '{1'b0, MD_NONE, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0};

      reset = 1'b1;
      drv(0, MD_NONE, 0, 0, 0, 0, 0);
      div_dout_tvalid = 1'b0; div_dout = '0; div_zero = 1'b0;
      repeat (2) @(negedge clock);
      rd(1, 0); chk("reset hi_lo rd_hi", hi_lo_data, 0);
      rd(0, 1); chk("reset hi_lo rd_lo", hi_lo_data, 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset stall", 32'(stall), 0);
      chk("reset div_tvalid", 32'(div_tvalid), 0);
      chk("reset mul_a", mul_a, 0);
      chk("reset div_divisor", div_divisor, 0);
      rd(0, 0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drv(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].h, vecs[i].l, vecs[i].f);
         #1;
         chk($sformatf("vec%0d hi_lo_data", i), hi_lo_data, vecs[i].ed);
         chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].es));
         chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].eb));
         @(negedge clock);
      end

      // divu by zero: HI/LO hold 0x11111111/0x22222222 from the table
      drv(1, MD_DIVU, 5, 0, 0, 0, 0);
      #1 chk("divz stall idle", 32'(stall), 0);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 0, 0, 0);
      #1;
      chk("divz tvalid issue", 32'(div_tvalid), 1);
      chk("divz dividend", div_dividend, 5);
      chk("divz divisor", div_divisor, 0);
      chk("divz signed", 32'(div_signed), 0);
      @(negedge clock);
      #1 chk("divz tvalid once", 32'(div_tvalid), 0);
      @(negedge clock);
      div_dout_tvalid = 1'b1; div_zero = 1'b1; div_dout = 64'hAAAAAAAA_BBBBBBBB;
      @(negedge clock);
      div_dout_tvalid = 1'b0; div_zero = 1'b0;
      #1;
      chk("divz pulse", 32'(divide_zero), 1);
      chk("divz busy done", 32'(busy), 0);
      @(negedge clock);
      #1 chk("divz pulse width", 32'(divide_zero), 0);
      rd(1, 0); chk("divz HI kept", hi_lo_data, 32'h11111111);
      rd(0, 1); chk("divz LO kept", hi_lo_data, 32'h22222222);
      rd(0, 0);

      mul_run("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      mul_run("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);

      // signed div -7/2 = -3 rem -1, mfhi held waiting for the result
      drv(1, MD_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 0, 0, 0);
      #1;
      chk("div tvalid", 32'(div_tvalid), 1);
      chk("div signed", 32'(div_signed), 1);
      chk("div dividend", div_dividend, 32'hFFFFFFF9);
      @(negedge clock);
      rd_hi = 1'b1;
      ok = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         if (i == 12) begin
            div_dout_tvalid = 1'b1;
            div_dout = 64'hFFFFFFFD_FFFFFFFF;
         end
         #1 ok = ok & stall & !div_tvalid;
         @(negedge clock);
      end
      div_dout_tvalid = 1'b0;
      chk("div stall until done", 32'(ok), 1);
      #1;
      chk("div stall released", 32'(stall), 0);
      chk("div HI rem", hi_lo_data, 32'hFFFFFFFF);
      rd(0, 1); chk("div LO quot", hi_lo_data, 32'hFFFFFFFD);
      rd(0, 0);

      // flush three cycles into DIV_WAIT, late result, mult offered in drain
      drv(1, MD_DIVU, 32'd100, 32'd7, 0, 0, 0);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      drv(1, MD_MULT, 32'd6, 32'd7, 0, 1, 0);
      ok = 1'b1;
      for (int j = 1; j <= 9; j++) begin
         if (j == 9) begin
            div_dout_tvalid = 1'b1;
            div_dout = 64'h0000000E_00000002;
         end
         #1 ok = ok & stall & busy;
         @(negedge clock);
      end
      div_dout_tvalid = 1'b0;
      chk("drain stall", 32'(ok), 1);
      #1;
      chk("drain exit stall", 32'(stall), 0);
      chk("late result dropped", hi_lo_data, 32'hFFFFFFFD);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 0, 0, 0);
      #1;
      chk("post-drain mult busy", 32'(busy), 1);
      chk("post-drain mul_a", mul_a, 6);
      chk("post-drain mul_b", mul_b, 7);
      c = 0;
      while (busy && c < 20) begin
         c++;
         @(negedge clock);
         #1;
      end
      chk("post-drain mult done", 32'(busy), 0);
      rd(0, 1); chk("post-drain LO", hi_lo_data, 32'h2A);
      rd(1, 0); chk("post-drain HI", hi_lo_data, 0);
      rd(0, 0);

      // mthi then mtlo held off by a running mult
      drv(1, MD_MTHI, 32'h12345678, 0, 0, 0, 0);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 1, 0, 0);
      #1 chk("mthi readback", hi_lo_data, 32'h12345678);
      drv(1, MD_MULT, 32'd2, 32'd3, 0, 0, 0);
      @(negedge clock);
      drv(1, MD_MTLO, 32'h55, 0, 0, 0, 0);
      c = 0;
      ok = 1'b1;
      while (busy && c < 20) begin
         #1 ok = ok & stall;
         @(negedge clock);
         c++;
      end
      chk("mtlo stalled in mul", 32'(ok), 1);
      chk("mtlo wait cycles", c, 5);
      rd(0, 1);
      chk("mtlo accept stall", 32'(stall), 0);
      chk("mult LO before mtlo", hi_lo_data, 6);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 0, 1, 0);
      #1 chk("mtlo LO", hi_lo_data, 32'h55);
      rd(1, 0); chk("mtlo HI from mult", hi_lo_data, 0);
      rd(0, 0);

      // divider never answers: timeout, drain, discarded late result
      drv(1, MD_DIV, 1, 1, 0, 0, 0);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 0, 0, 0);
      c = 0;
      while (!div_timeout && c < 60) begin
         @(negedge clock);
         c++;
         #1;
      end
      chk("timeout seen", 32'(div_timeout), 1);
      @(negedge clock);
      #1;
      chk("timeout pulse width", 32'(div_timeout), 0);
      chk("timeout drain busy", 32'(busy), 1);
      div_dout_tvalid = 1'b1;
      div_dout = 64'h00000001_00000000;
      @(negedge clock);
      div_dout_tvalid = 1'b0;
      #1 chk("timeout drain exit", 32'(busy), 0);
      rd(0, 1); chk("timeout LO kept", hi_lo_data, 32'h55);
      rd(0, 0);

      // reset in the middle of a mult, then a stray divider result
      drv(1, MD_MULT, 32'd3, 32'd3, 0, 0, 0);
      @(negedge clock);
      drv(0, MD_NONE, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("midreset busy", 32'(busy), 0);
      chk("midreset mul_a", mul_a, 0);
      rd(0, 1); chk("midreset LO", hi_lo_data, 0);
      div_dout_tvalid = 1'b1;
      div_dout = 64'h12121212_34343434;
      @(negedge clock);
      div_dout_tvalid = 1'b0;
      repeat (6) @(negedge clock);
      #1;
      chk("midreset stray busy", 32'(busy), 0);
      rd(1, 0); chk("midreset HI", hi_lo_data, 0);
      rd(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
